// File: rtl/instr_encoder_loader_if.sv
// Request and instruction-memory bus of the program preloader.
// slave: the loader's view. master: the boot sequencer / bench view.
// Request fields arrive with in_valid_i. The memory side is a held write strobe that completes on mem_ack_i.
interface instr_encoder_loader_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [3:0]  kind_i;
    logic [4:0]  rs_i;
    logic [4:0]  rt_i;
    logic [4:0]  rd_i;
    logic [5:0]  funct_i;
    logic [15:0] imm_i;
    logic [25:0] target_i;
    logic        flush_i;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_ack_i;
    logic        done_o;
    logic        err_o;
    logic [15:0] words_o;

    modport slave (
        input  in_valid_i, kind_i, rs_i, rt_i, rd_i, funct_i, imm_i, target_i,
        input  flush_i, mem_ack_i,
        output in_ready_o, mem_we_o, mem_addr_o, mem_data_o, done_o, err_o, words_o
    );

    modport master (
        output in_valid_i, kind_i, rs_i, rt_i, rd_i, funct_i, imm_i, target_i,
        output flush_i, mem_ack_i,
        input  in_ready_o, mem_we_o, mem_addr_o, mem_data_o, done_o, err_o, words_o
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic instruction requests into 32-bit words and streams them into instruction memory.
// Latency: request accepted at edge N -> mem_we_o high after edge N+1; at most one word per 2 cycles.
// Backpressure: in_ready_o = !fifo_full; a write is held on the memory bus until mem_ack_i.
// Ports: clk_i, rst_i (async active-low), bus (slave): request in, memory write out, flush/done, err, words.
module instr_encoder_loader #(
    parameter int          DEPTH     = 4,
    parameter int          MEM_WORDS = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    instr_encoder_loader_if.slave bus
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (MEM_WORDS - 1));

    typedef enum logic {IDLE, WRITE} state_t;

    state_t      state_q, state_d;
    logic [31:0] fifo_mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_full, fifo_empty;
    logic [31:0] enc_word;
    logic        kind_legal;
    logic        accept, push, pop, ack_take, done;
    logic [31:0] mem_addr_q, mem_data_q;
    logic [15:0] words_q;
    logic        err_q, flush_pend_q;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign accept = bus.in_valid_i && !fifo_full;
    // Illegal kinds complete the handshake but are never stored.
    assign push   = accept && kind_legal;

    // Opcode map, combinational on the request fields.
    always_comb begin
        enc_word   = 32'd0;
        kind_legal = 1'b1;
        case (bus.kind_i)
            4'd0:  enc_word = {6'b000000, bus.rs_i, bus.rt_i, bus.rd_i, 5'd0, bus.funct_i};
            4'd1:  enc_word = {6'b000000, bus.rs_i, 5'd0, 5'd0, 5'd0, 6'b001000};
            4'd2:  enc_word = {6'b001000, bus.rs_i, bus.rt_i, bus.imm_i};
            4'd3:  enc_word = {6'b101100, bus.rs_i, bus.rt_i, bus.imm_i};
            4'd4:  enc_word = {6'b101101, bus.rs_i, bus.rt_i, bus.imm_i};
            4'd5:  enc_word = {6'b001010, bus.rs_i, bus.rt_i, bus.imm_i};
            4'd6:  enc_word = {6'b001011, bus.rs_i, bus.rt_i, bus.imm_i};
            4'd7:  enc_word = {6'b001100, bus.rs_i, 5'd0, bus.imm_i};
            4'd8:  enc_word = {6'b000010, bus.target_i};
            4'd9:  enc_word = {6'b000011, bus.target_i};
            4'd10: enc_word = {6'b001110, bus.rs_i, bus.rt_i, bus.imm_i};
            4'd11: enc_word = {6'b001101, bus.rs_i, 5'd0, bus.imm_i};
            default: kind_legal = 1'b0;
        endcase
    end

    // Writer FSM: pop into the output register, then hold the write until acked.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        ack_take = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (bus.mem_ack_i) begin
                    ack_take = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Flush completes only once nothing is queued, in flight, or arriving this edge.
    assign done = flush_pend_q && (state_q == IDLE) && fifo_empty && !accept;

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= enc_word;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            mem_addr_q   <= BASE_ADDR;
            mem_data_q   <= 32'd0;
            words_q      <= 16'd0;
            err_q        <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (pop) begin
                rd_ptr     <= rd_ptr + {{AW{1'b0}}, 1'b1};
                mem_data_q <= fifo_mem[rd_ptr[AW-1:0]];
            end
            if (ack_take) begin
                words_q    <= words_q + 16'd1;
                mem_addr_q <= (mem_addr_q == LAST_ADDR) ? BASE_ADDR : mem_addr_q + 32'd4;
            end
            if (accept && !kind_legal) err_q <= 1'b1;
            if (done)              flush_pend_q <= 1'b0;
            else if (bus.flush_i)  flush_pend_q <= 1'b1;
        end
    end

    assign bus.in_ready_o = !fifo_full;
    assign bus.mem_we_o   = (state_q == WRITE);
    assign bus.mem_addr_o = mem_addr_q;
    assign bus.mem_data_o = mem_data_q;
    assign bus.done_o     = done;
    assign bus.err_o      = err_q;
    assign bus.words_o    = words_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed scenarios plus randomized traffic.
// The expected word stream comes from an arithmetic encoder model and is held in a scoreboard queue.
// A monitor pops and compares on every acked write.
module tb_instr_encoder_loader;
    localparam int          DEPTH     = 4;
    localparam int          MEM_WORDS = 32;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_encoder_loader_if bus();

    instr_encoder_loader #(
        .DEPTH(DEPTH), .MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_mode = 0;          // 0 never ack, 1 random, 2 always
    int done_cnt = 0;
    int done_cyc = 0;
    int last_ack_cyc = 0;
    bit flush_exp = 0;
    logic [31:0] exp_q[$];
    int op_tab[12] = '{0, 0, 8, 44, 45, 10, 11, 12, 2, 3, 14, 13};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction word assembled from field weights.
    function automatic logic [31:0] ref_encode(int kind, int rs, int rt, int rd, int funct,
                                               int imm, int target);
        longint w;
        int rtv;
        w = 0;
        if (kind == 0)
            w = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048 + funct;
        else if (kind == 1)
            w = longint'(rs) * 2097152 + 8;
        else if (kind == 8 || kind == 9)
            w = longint'(op_tab[kind]) * 67108864 + target;
        else if (kind < 12) begin
            rtv = (kind == 7 || kind == 11) ? 0 : rt;
            w = longint'(op_tab[kind]) * 67108864 + longint'(rs) * 2097152
                + longint'(rtv) * 65536 + imm;
        end
        return w[31:0];
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        bus.mem_ack_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ack_mode)
                0:       bus.mem_ack_i = 1'b0;
                1:       bus.mem_ack_i = 1'($urandom_range(0, 1));
                default: bus.mem_ack_i = 1'b1;
            endcase
        end
    end

    // Write monitor: scoreboard pop, stall stability, word counter and address sequence.
    initial begin
        int widx = 0;
        int wexp = 0;
        bit prev_stall = 0;
        logic [31:0] prev_addr = '0, prev_data = '0, exp_word;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                widx = 0; wexp = 0; prev_stall = 0;
            end else begin
                chk("words_count", 32'(bus.words_o), 32'(wexp % 65536));
                if (prev_stall) begin
                    chk("stall_we", 32'(bus.mem_we_o), 32'd1);
                    chk("stall_addr", bus.mem_addr_o, prev_addr);
                    chk("stall_data", bus.mem_data_o, prev_data);
                end
                if (bus.mem_we_o && bus.mem_ack_i) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_write actual=%h required=none", bus.mem_data_o);
                    end else begin
                        exp_word = exp_q.pop_front();
                        chk("write_data", bus.mem_data_o, exp_word);
                        chk("write_addr", bus.mem_addr_o, BASE_ADDR + 32'(4 * (widx % MEM_WORDS)));
                    end
                    widx++; wexp++;
                    last_ack_cyc = cyc;
                end
                prev_stall = bus.mem_we_o && !bus.mem_ack_i;
                prev_addr  = bus.mem_addr_o;
                prev_data  = bus.mem_data_o;
            end
        end
    end

    // Done monitor: every pulse must answer a flush and find the pipeline drained.
    initial forever begin
        @(negedge clk);
        if (rst_n && bus.done_o) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_requested", 32'(flush_exp), 32'd1);
            chk("done_drained", 32'(exp_q.size()), 32'd0);
            flush_exp = 0;
        end
    end

    task automatic send(input int kind, input int rs, input int rt, input int rd,
                        input int funct, input int imm, input int target);
        bit ok = 0;
        bus.kind_i = kind[3:0]; bus.rs_i = rs[4:0]; bus.rt_i = rt[4:0]; bus.rd_i = rd[4:0];
        bus.funct_i = funct[5:0]; bus.imm_i = imm[15:0]; bus.target_i = target[25:0];
        bus.in_valid_i = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            ok = bus.in_ready_o;
            @(posedge clk);
            if (ok && kind < 12) exp_q.push_back(ref_encode(kind, rs, rt, rd, funct, imm, target));
            #1;
        end
        bus.in_valid_i = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=not_ready required=ready");
        end
    endtask

    task automatic send_rand(input int kind);
        send(kind, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 63), $urandom_range(0, 65535), $urandom_range(0, 67108863));
    endtask

    task automatic wait_drain();
        bit ok = 0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk); #1;
            ok = (exp_q.size() == 0) && !bus.mem_we_o;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic expect_head(input string name, input logic [31:0] word);
        bit ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.mem_we_o;
        end
        chk(name, bus.mem_data_o, word);
    endtask

    task automatic flush_pulse();
        flush_exp = 1;
        bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
    endtask

    task automatic wait_done();
        int start = done_cnt;
        for (int i = 0; i < 600 && done_cnt == start; i++) @(negedge clk);
        if (done_cnt == start) begin
            checks++; errors++;
            $display("FAIL done_timeout actual=0 required=1");
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        flush_exp = 0;
        bus.in_valid_i = 1'b0; bus.flush_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int w0, dstart, nlegal;
        bit any_illegal;
        bus.in_valid_i = 1'b0; bus.flush_i = 1'b0; bus.kind_i = '0; bus.rs_i = '0;
        bus.rt_i = '0; bus.rd_i = '0; bus.funct_i = '0; bus.imm_i = '0; bus.target_i = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_we", 32'(bus.mem_we_o), 32'd0);
        chk("rst_addr", bus.mem_addr_o, BASE_ADDR);
        chk("rst_data", bus.mem_data_o, 32'd0);
        chk("rst_done", 32'(bus.done_o), 32'd0);
        chk("rst_err", 32'(bus.err_o), 32'd0);
        chk("rst_words", 32'(bus.words_o), 32'd0);
        chk("rst_ready", 32'(bus.in_ready_o), 32'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // First-write latency: ADDI rs=1 rt=2 imm=5
        ack_mode = 0;
        send(2, 1, 2, 0, 0, 5, 0);
        @(negedge clk);
        chk("lat_we_n", 32'(bus.mem_we_o), 32'd0);
        @(negedge clk);
        chk("lat_we_n1", 32'(bus.mem_we_o), 32'd1);
        chk("lat_addr", bus.mem_addr_o, 32'h0);
        chk("lat_data", bus.mem_data_o, 32'h2022_0005);
        ack_mode = 2;
        wait_drain();
        chk("lat_words", 32'(bus.words_o), 32'd1);
        chk("lat_next_addr", bus.mem_addr_o, 32'h4);

        // Stalled write holds, then RTYPE/JR/JAL at 0x0/0x4/0x8
        do_reset();
        ack_mode = 0;
        send(0, 1, 2, 3, 6'h20, 0, 0);
        send(1, 31, 0, 0, 0, 0, 0);
        send(9, 0, 0, 0, 0, 0, 26'h10);
        repeat (3) @(negedge clk);
        chk("stall_head", bus.mem_data_o, 32'h0022_1820);
        ack_mode = 2;
        wait_drain();
        chk("stall_words", 32'(bus.words_o), 32'd3);
        chk("stall_next_addr", bus.mem_addr_o, 32'hC);

        // LW and BNEZ (rt forced 0)
        ack_mode = 0;
        send(3, 0, 8, 0, 0, 4, 0);
        expect_head("lw_word", 32'hB008_0004);
        ack_mode = 2;
        wait_drain();
        ack_mode = 0;
        send(7, 3, 5, 0, 0, 16'hFFFE, 0);
        expect_head("bnez_word", 32'h3060_FFFE);
        ack_mode = 2;
        wait_drain();

        // Backpressure: DEPTH in FIFO plus one in the output register
        ack_mode = 0;
        w0 = bus.words_o;
        for (int i = 0; i < 5; i++) send(2, i, i + 1, 0, 0, 100 + i, 0);
        chk("full_ready", 32'(bus.in_ready_o), 32'd0);
        bus.kind_i = 4'd2; bus.in_valid_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.in_valid_i = 1'b0;
        chk("full_ready_hold", 32'(bus.in_ready_o), 32'd0);
        ack_mode = 2;
        wait_drain();
        chk("full_words", 32'(bus.words_o), 32'(w0 + 5));

        // Illegal kind between two ADDIs
        ack_mode = 1;
        chk("err_before", 32'(bus.err_o), 32'd0);
        w0 = bus.words_o;
        send(2, 4, 5, 0, 0, 7, 0);
        send_rand(13);
        send(2, 6, 7, 0, 0, 9, 0);
        wait_drain();
        chk("err_set", 32'(bus.err_o), 32'd1);
        chk("illegal_words", 32'(bus.words_o), 32'(w0 + 2));

        // Flush after 3 requests; second flush while pending adds nothing
        ack_mode = 2;
        dstart = done_cnt;
        send(2, 1, 1, 0, 0, 1, 0);
        send(2, 2, 2, 0, 0, 2, 0);
        flush_pulse();
        send(2, 3, 3, 0, 0, 3, 0);
        flush_pulse();
        wait_done();
        chk("done_timing", 32'(done_cyc), 32'(last_ack_cyc + 1));
        repeat (5) @(posedge clk);
        #1 chk("done_once", 32'(done_cnt - dstart), 32'd1);
        chk("err_sticky", 32'(bus.err_o), 32'd1);

        // Flush with everything idle: done the next cycle, one cycle wide
        flush_pulse();
        @(negedge clk);
        chk("idle_done", 32'(bus.done_o), 32'd1);
        @(negedge clk);
        chk("idle_done_clear", 32'(bus.done_o), 32'd0);
        @(posedge clk); #1;

        // Random traffic with random ack; wraps past MEM_WORDS
        do_reset();
        ack_mode = 1;
        nlegal = 0; any_illegal = 0;
        for (int i = 0; i < 50; i++) begin
            int k = $urandom_range(0, 13);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_rand(k);
            if (k < 12) nlegal++; else any_illegal = 1;
        end
        flush_pulse();
        wait_done();
        chk("rand_words", 32'(bus.words_o), 32'(nlegal));
        chk("rand_err", 32'(bus.err_o), 32'(any_illegal));

        // Reset asserted mid-write
        ack_mode = 0;
        send(2, 1, 2, 0, 0, 5, 0);
        @(posedge clk); #1;
        chk("mid_we_before", 32'(bus.mem_we_o), 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_we", 32'(bus.mem_we_o), 32'd0);
        chk("mid_rst_addr", bus.mem_addr_o, BASE_ADDR);
        chk("mid_rst_data", bus.mem_data_o, 32'd0);
        chk("mid_rst_words", 32'(bus.words_o), 32'd0);
        chk("mid_rst_err", 32'(bus.err_o), 32'd0);
        chk("mid_rst_done", 32'(bus.done_o), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("post_rst_we", 32'(bus.mem_we_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Inverse of the main control decoder. It accepts symbolic instruction requests (kind plus fields) on a valid/ready handshake and encodes them into 32-bit MIPS-style words using the lab opcode map. It buffers the words in a small FIFO and writes them sequentially into instruction memory through a write/ack handshake. It sits between the testbench/boot sequencer and Instr_Memory and is used to preload programs before the CPU is released from reset.

Parameters:
DEPTH, 4, encoded-word FIFO depth (power of 2, >=2)
MEM_WORDS, 32, instruction memory size in words; address wrap point
BASE_ADDR, 32'h0000_0000, byte address of the first word written

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-low
in_valid_i  input  1  request valid
in_ready_o  output  1  request accepted on edge where valid&ready
kind_i  input  4  instruction kind (see Behaviour)
rs_i  input  5  rs field
rt_i  input  5  rt field
rd_i  input  5  rd field
funct_i  input  6  funct for kind RTYPE
imm_i  input  16  immediate for I-format
target_i  input  26  jump target for J-format
flush_i  input  1  pulse: request done_o once all accepted words are written
mem_we_o  output  1  instruction memory write strobe
mem_addr_o  output  32  byte address
mem_data_o  output  32  encoded word
mem_ack_i  input  1  memory accepted the write this cycle
done_o  output  1  one-cycle pulse, flush complete
err_o  output  1  sticky: an illegal kind was received
words_o  output  16  count of words written (wraps at 2^16)

Behaviour:
- Reset (rst_i=0, async): FIFO empty, FSM IDLE, mem_we_o=0, mem_addr_o=BASE_ADDR, mem_data_o=0, done_o=0, err_o=0, words_o=0, flush pending cleared. An in-flight write is abandoned; mem_we_o drops immediately.
- Kind map (op[31:26]): 0 RTYPE op=000000, {rs,rt,rd,shamt=0,funct_i}; 1 JR op=000000, rs, rt=rd=shamt=0, funct=001000; 2 ADDI 001000; 3 LW 101100; 4 SW 101101; 5 BEQ 001010; 6 BNE 001011; 7 BNEZ 001100, rt forced 0; 8 J 000010; 9 JAL 000011; 10 BLT 001110; 11 BGEZ 001101, rt forced 0. I-format is {op,rs,rt,imm_i}. J-format is {op,target_i}.
- Kinds 12-15 are illegal. They are handshaken normally (ready per FIFO state), not stored, and set err_o. err_o clears only on reset.
- Encoding is combinational on inputs. The encoded word is pushed into the FIFO on the accepting edge.
- in_ready_o = !full. There is no push when full, even if a pop occurs the same cycle. There is no bypass when empty.
- Writer FSM IDLE/WRITE:
  - IDLE with FIFO non-empty: pop the head into mem_data_o, go to WRITE. mem_we_o=1 from the cycle after that edge.
  - First write latency: a request accepted at edge N sets mem_we_o high after edge N+1 (FIFO stage plus pop stage).
  - WRITE: mem_we_o, mem_addr_o and mem_data_o are held stable until mem_ack_i=1.
  - On the ack edge: mem_we_o=0, words_o+=1, mem_addr_o+=4, return to IDLE. Maximum throughput is one word per 2 cycles.
  - Ack in IDLE is ignored.
- Address wrap: after a write at BASE_ADDR+4*(MEM_WORDS-1), mem_addr_o returns to BASE_ADDR.
- Flush:
  - flush_i sets a pending flag.
  - done_o pulses for one cycle on the first cycle with flag set, FSM IDLE, FIFO empty and no accept on that edge. The flag clears with the pulse.
  - flush_i while already pending has no extra effect.
  - flush_i with everything idle produces done_o in the next cycle.
- Requests accepted after flush_i but before done_o are written before done_o fires.

Test Plan:
- Reset, then ADDI rs=1 rt=2 imm=5 -> mem_we_o rises 2 cycles after accept; addr 0x0, data 0x20220005; on ack words_o=1 and addr becomes 0x4.
- RTYPE rs=1 rt=2 rd=3 funct=0x20, JR rs=31, JAL target=0x10, held with mem_ack_i=0 for 3 cycles -> data stays 0x00221820 while stalled; then writes 0x03E00008 and 0x0C000010 at 0x0, 0x4, 0x8.
- LW rs=0 rt=8 imm=4 and BNEZ rs=3 rt=5 imm=0xFFFE -> 0xB0080004 and 0x3060FFFE (rt forced 0).
- mem_ack_i held 0, push 5 requests with DEPTH=4 -> 4 accepted plus 1 in the output register, in_ready_o=0 on the next request; release ack -> all written in order.
- Kind 13 sent between two ADDIs -> err_o=1 stays set, only 2 words written, addresses contiguous; write 33 words with MEM_WORDS=32 -> 33rd lands at 0x0.
- flush_i after 3 requests -> done_o pulses exactly once, the cycle after the 3rd ack; assert rst_i=0 mid-WRITE -> mem_we_o=0 immediately and all outputs at reset values.
